vx_task_dispatch: RTL and testbench
===================================

VX_TASK_DISPATCH -- requirements
Module: VX_task_dispatch

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 1: number of task sources.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 4: number of sockets or cores that receive tasks.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: task payload width.
REQ-004 SHALL have parameter MAX_PENDING, default 4: maximum number of tasks outstanding per output.
REQ-005 SHALL have parameter POLICY, default 0: 0 = round-robin, 1 = least-loaded.
REQ-006 SHALL have parameter OUT_BUF, default 1: 1 = registered output slot, 0 = combinational pass-through.
REQ-007 SHALL use one clock; reset is asynchronous and active-high.
REQ-008 SHALL have port clk, input, 1 bit: clock.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-010 SHALL have port in_valid, input, NUM_INPUTS bits: task offered per source.
REQ-011 SHALL have port in_data, input, NUM_INPUTS*DATA_WIDTH bits: task payloads.
REQ-012 SHALL have port in_ready, output, NUM_INPUTS bits: task accepted per source.
REQ-013 SHALL have port out_valid, output, NUM_OUTPUTS bits: task presented per output.
REQ-014 SHALL have port out_data, output, NUM_OUTPUTS*DATA_WIDTH bits: task payloads.
REQ-015 SHALL have port out_ready, input, NUM_OUTPUTS bits: output accepts.
REQ-016 SHALL have port done, input, NUM_OUTPUTS bits: one-cycle task-completion pulses.
REQ-017 SHALL have port pending, output, NUM_OUTPUTS*CNTW bits, where CNTW = $clog2(MAX_PENDING+1): outstanding count per output.
REQ-018 SHALL have port busy, output, 1 bit: any activity.

Function
REQ-019 SHALL accept at most one input task per cycle, chosen by round-robin among asserted in_valid; the pointer advances past the winner only on acceptance.
REQ-020 An output SHALL be eligible when pending < MAX_PENDING and its slot is empty (OUT_BUF=1) or out_ready=1 (OUT_BUF=0).
REQ-021 POLICY=0 SHALL select the first eligible output at or after rr_out_ptr, and SHALL advance the pointer to the winner+1 modulo NUM_OUTPUTS on dispatch.
REQ-022 POLICY=1 SHALL select the eligible output with the minimum pending; ties go to the lowest index.
REQ-023 in_ready[i] SHALL be 1 only for the granted input, and only when at least one output is eligible; with no eligible output, every in_ready SHALL be 0.
REQ-024 With OUT_BUF=1, a dispatched task SHALL load the target slot, appear on out_valid the next cycle (latency 1), and be held stable until out_ready.
REQ-025 With OUT_BUF=1, the slot SHALL NOT accept a new task in the same cycle it drains; the result is 1 task per 2 cycles per output and full rate across outputs.
REQ-026 With OUT_BUF=0, in_data SHALL be routed combinationally to the target output, with out_valid asserted in the same cycle (latency 0).
REQ-027 pending[j] SHALL increment on dispatch to j, decrement on done[j], and stay unchanged when both occur in the same cycle.
REQ-028 done[j] SHALL be ignored when pending[j]==0 (no underflow); dispatch never exceeds MAX_PENDING.
REQ-029 busy SHALL be the OR of in_valid, all out_valid, and all non-zero pending values.

Reset
REQ-030 On reset assertion (async), SHALL clear all slots, counters, and pointers, and drive out_valid=0, in_ready=0, pending=0, busy=0.
REQ-031 A task held in a slot when reset asserts mid-operation SHALL be discarded, not replayed.
REQ-032 Reset deassertion SHALL permit dispatch from the first following clock edge.

Structure
REQ-033 The POLICY encodings (DISPATCH_RR, DISPATCH_LL) SHALL be localparams in VX_gpu_pkg.
REQ-034 A per-output sub-module, VX_task_dispatch_slot, SHALL contain the buffer and pending counter; the top level SHALL instantiate NUM_OUTPUTS of them plus the input round-robin and output selection logic.

Verification
REQ-035 With POLICY=0, NUM_OUTPUTS=4, out_ready=1 and no done, 8 back-to-back tasks SHALL land on outputs 0,1,2,3,0,1,2,3, and pending SHALL equal 2 on each output.
REQ-036 With POLICY=1, pending={3,1,1,2} and a new task offered, the task SHALL go to output 1; a following task SHALL go to output 2.
REQ-037 With MAX_PENDING=2 and all outputs at 2, in_ready SHALL be 0; a done[2] pulse SHALL let the next task dispatch to output 2 in the following cycle.
REQ-038 Simultaneous dispatch and done on output 0 with pending=1 SHALL leave pending at 1; done on an output with pending=0 SHALL leave it at 0.
REQ-039 With OUT_BUF=1 and out_ready[0]=0 held for 5 cycles, out_data[0] SHALL stay stable; reset asserted in cycle 3 SHALL clear out_valid[0] asynchronously.
REQ-040 With NUM_INPUTS=2 and both inputs valid continuously, grants SHALL alternate 0,1,0,1, with no starvation over 16 tasks.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// ----------------------------------------------------------------------------
// vx_gpu_pkg
// Shared definitions for the task dispatch block.
//   DISPATCH_RR / DISPATCH_LL : encodings for the dispatcher POLICY parameter
//   cnt_width()               : width needed to hold a count of 0..max_pending
// ----------------------------------------------------------------------------
package vx_gpu_pkg;

    localparam int DISPATCH_RR = 0;
    localparam int DISPATCH_LL = 1;

    function automatic int cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/vx_task_dispatch_slot.sv
// ----------------------------------------------------------------------------
// vx_task_dispatch_slot
// One per output: holds the output buffer (or pass-through path) and the
// outstanding-task counter, and reports whether this output can take a task.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   dispatch            : a task is being sent to this output this cycle
//   dispatch_data       : payload of that task
//   done                : one-cycle completion pulse from the consumer
//   out_ready           : consumer accepts the presented task
//   out_valid, out_data : task presented to the consumer
//   pending             : number of tasks outstanding on this output
//   eligible            : this output can accept a dispatch this cycle
// ----------------------------------------------------------------------------
module vx_task_dispatch_slot
    import vx_gpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_PENDING = 4,
    parameter int OUT_BUF     = 1,
    parameter int CNTW        = cnt_width(MAX_PENDING)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch,
    input  logic [DATA_WIDTH-1:0] dispatch_data,
    input  logic                  done,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNTW-1:0]       pending,
    output logic                  eligible
);

    logic [CNTW-1:0] count;
    logic            can_take;
    logic            dec;

    assign can_take = (count < CNTW'(MAX_PENDING));

    // A completion with nothing outstanding is dropped so the counter
    // can never wrap below zero.
    assign dec = done && (count != '0);

    // Dispatch and completion in the same cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (dispatch && !dec) begin
            count <= count + CNTW'(1);
        end else if (!dispatch && dec) begin
            count <= count - CNTW'(1);
        end
    end

    assign pending = count;

    generate
        if (OUT_BUF != 0) begin : g_buf
            logic                  slot_valid;
            logic [DATA_WIDTH-1:0] slot_data;

            // The slot only loads when empty, so a load and a drain never
            // coincide; a draining slot becomes free on the following cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_valid <= 1'b0;
                    slot_data  <= '0;
                end else if (dispatch) begin
                    slot_valid <= 1'b1;
                    slot_data  <= dispatch_data;
                end else if (slot_valid && out_ready) begin
                    slot_valid <= 1'b0;
                end
            end

            assign out_valid = slot_valid;
            assign out_data  = slot_data;
            assign eligible  = can_take && !slot_valid;
        end else begin : g_pass
            // Pass-through: the task is only ever dispatched here when the
            // consumer is ready, so the handshake completes in this cycle.
            assign out_valid = dispatch;
            assign out_data  = dispatch_data;
            assign eligible  = can_take && out_ready;
        end
    endgenerate

endmodule

// File: rtl/vx_task_dispatch.sv
// ----------------------------------------------------------------------------
// vx_task_dispatch
// Accepts at most one task per cycle from NUM_INPUTS sources (round-robin)
// and sends it to one of NUM_OUTPUTS consumers, chosen round-robin or by
// least outstanding work. Tracks outstanding tasks per output via done.
//
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : task offered per source          (NUM_INPUTS)
//   in_data    : task payloads                    (NUM_INPUTS*DATA_WIDTH)
//   in_ready   : task accepted per source         (NUM_INPUTS)
//   out_valid  : task presented per output        (NUM_OUTPUTS)
//   out_data   : task payloads                    (NUM_OUTPUTS*DATA_WIDTH)
//   out_ready  : output accepts                   (NUM_OUTPUTS)
//   done       : task completion pulses           (NUM_OUTPUTS)
//   pending    : outstanding count per output     (NUM_OUTPUTS*CNTW)
//   busy       : any input, output or outstanding activity
// ----------------------------------------------------------------------------
module vx_task_dispatch
    import vx_gpu_pkg::*;
#(
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int MAX_PENDING = 4,
    parameter int POLICY      = 0,
    parameter int OUT_BUF     = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_INPUTS-1:0]                        in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]             in_data,
    output logic [NUM_INPUTS-1:0]                        in_ready,
    output logic [NUM_OUTPUTS-1:0]                       out_valid,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]            out_data,
    input  logic [NUM_OUTPUTS-1:0]                       out_ready,
    input  logic [NUM_OUTPUTS-1:0]                       done,
    output logic [NUM_OUTPUTS*cnt_width(MAX_PENDING)-1:0] pending,
    output logic                                         busy
);

    localparam int CNTW = cnt_width(MAX_PENDING);
    localparam int IW   = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int OW   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    logic [IW-1:0]          rr_in_ptr;
    logic [OW-1:0]          rr_out_ptr;
    logic                   in_found;
    logic [IW-1:0]          in_sel;
    logic                   out_found;
    logic [OW-1:0]          out_sel;
    logic [NUM_OUTPUTS-1:0] eligible;
    logic [NUM_OUTPUTS-1:0] dispatch_vec;
    logic [CNTW-1:0]        pend_arr [NUM_OUTPUTS];
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   fire;

    // Input arbitration: first valid source at or after the pointer.
    always_comb begin : p_in_arb
        int idx;
        idx      = 0;
        in_found = 1'b0;
        in_sel   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = (int'(rr_in_ptr) + k) % NUM_INPUTS;
            if (!in_found && in_valid[idx]) begin
                in_found = 1'b1;
                in_sel   = IW'(idx);
            end
        end
    end

    // Output selection. Least-loaded uses a strict compare so the lowest
    // index wins ties; round-robin scans from the output pointer.
    always_comb begin : p_out_sel
        int              idx;
        logic [CNTW-1:0] best;
        idx       = 0;
        best      = '0;
        out_found = 1'b0;
        out_sel   = '0;
        if (POLICY == DISPATCH_LL) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                if (eligible[j] && (!out_found || pend_arr[j] < best)) begin
                    out_found = 1'b1;
                    out_sel   = OW'(j);
                    best      = pend_arr[j];
                end
            end
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                idx = (int'(rr_out_ptr) + k) % NUM_OUTPUTS;
                if (!out_found && eligible[idx]) begin
                    out_found = 1'b1;
                    out_sel   = OW'(idx);
                end
            end
        end
    end

    // Nothing is accepted while reset is held, so in_ready and the
    // pass-through out_valid both read zero during reset.
    assign fire         = !reset && in_found && out_found;
    assign in_ready     = fire ? (NUM_INPUTS'(1) << in_sel) : '0;
    assign dispatch_vec = fire ? (NUM_OUTPUTS'(1) << out_sel) : '0;
    assign sel_data     = in_data[int'(in_sel)*DATA_WIDTH +: DATA_WIDTH];

    // Both pointers move past their winners only when a task is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_in_ptr  <= '0;
            rr_out_ptr <= '0;
        end else if (fire) begin
            rr_in_ptr  <= (int'(in_sel) == NUM_INPUTS - 1)   ? '0 : in_sel + IW'(1);
            rr_out_ptr <= (int'(out_sel) == NUM_OUTPUTS - 1) ? '0 : out_sel + OW'(1);
        end
    end

    generate
        for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_slot
            vx_task_dispatch_slot #(
                .DATA_WIDTH  (DATA_WIDTH),
                .MAX_PENDING (MAX_PENDING),
                .OUT_BUF     (OUT_BUF),
                .CNTW        (CNTW)
            ) u_slot (
                .clk           (clk),
                .reset         (reset),
                .dispatch      (dispatch_vec[j]),
                .dispatch_data (sel_data),
                .done          (done[j]),
                .out_ready     (out_ready[j]),
                .out_valid     (out_valid[j]),
                .out_data      (out_data[j*DATA_WIDTH +: DATA_WIDTH]),
                .pending       (pend_arr[j]),
                .eligible      (eligible[j])
            );
            assign pending[j*CNTW +: CNTW] = pend_arr[j];
        end
    endgenerate

    assign busy = !reset && ((|in_valid) || (|out_valid) || (|pending));

endmodule

// File: tb/tb_vx_task_dispatch.sv
// ----------------------------------------------------------------------------
// tb_vx_task_dispatch
// Three dispatcher configurations driven with directed vectors:
//   u_rr : 2 inputs, round-robin, buffered outputs, MAX_PENDING=8
//   u_ll : 1 input, least-loaded, pass-through outputs, MAX_PENDING=4
//   u_mp : 1 input, round-robin, buffered outputs, MAX_PENDING=2
// ----------------------------------------------------------------------------
module tb_vx_task_dispatch;

    logic clk;
    logic reset;

    int total;
    int bad;

    logic [1:0]  rr_in_valid;
    logic [31:0] rr_in_data;
    logic [1:0]  rr_in_ready;
    logic [3:0]  rr_out_valid;
    logic [63:0] rr_out_data;
    logic [3:0]  rr_out_ready;
    logic [3:0]  rr_done;
    logic [15:0] rr_pending;
    logic        rr_busy;

    logic [0:0]  ll_in_valid;
    logic [15:0] ll_in_data;
    logic [0:0]  ll_in_ready;
    logic [3:0]  ll_out_valid;
    logic [63:0] ll_out_data;
    logic [3:0]  ll_out_ready;
    logic [3:0]  ll_done;
    logic [11:0] ll_pending;
    logic        ll_busy;

    logic [0:0]  mp_in_valid;
    logic [15:0] mp_in_data;
    logic [0:0]  mp_in_ready;
    logic [3:0]  mp_out_valid;
    logic [63:0] mp_out_data;
    logic [3:0]  mp_out_ready;
    logic [3:0]  mp_done;
    logic [7:0]  mp_pending;
    logic        mp_busy;

    vx_task_dispatch #(
        .NUM_INPUTS(2), .NUM_OUTPUTS(4), .DATA_WIDTH(16),
        .MAX_PENDING(8), .POLICY(0), .OUT_BUF(1)
    ) u_rr (
        .clk(clk), .reset(reset),
        .in_valid(rr_in_valid), .in_data(rr_in_data), .in_ready(rr_in_ready),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_ready(rr_out_ready),
        .done(rr_done), .pending(rr_pending), .busy(rr_busy)
    );

    vx_task_dispatch #(
        .NUM_INPUTS(1), .NUM_OUTPUTS(4), .DATA_WIDTH(16),
        .MAX_PENDING(4), .POLICY(1), .OUT_BUF(0)
    ) u_ll (
        .clk(clk), .reset(reset),
        .in_valid(ll_in_valid), .in_data(ll_in_data), .in_ready(ll_in_ready),
        .out_valid(ll_out_valid), .out_data(ll_out_data), .out_ready(ll_out_ready),
        .done(ll_done), .pending(ll_pending), .busy(ll_busy)
    );

    vx_task_dispatch #(
        .NUM_INPUTS(1), .NUM_OUTPUTS(4), .DATA_WIDTH(16),
        .MAX_PENDING(2), .POLICY(0), .OUT_BUF(1)
    ) u_mp (
        .clk(clk), .reset(reset),
        .in_valid(mp_in_valid), .in_data(mp_in_data), .in_ready(mp_in_ready),
        .out_valid(mp_out_valid), .out_data(mp_out_data), .out_ready(mp_out_ready),
        .done(mp_done), .pending(mp_pending), .busy(mp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        rr_in_valid = '0; rr_in_data = '0; rr_out_ready = '0; rr_done = '0;
        ll_in_valid = '0; ll_in_data = '0; ll_out_ready = '0; ll_done = '0;
        mp_in_valid = '0; mp_in_data = '0; mp_out_ready = '0; mp_done = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        rr_in_valid = 2'b11;
        mp_in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (rr_in_ready !== 2'b00) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=00", rr_in_ready);
        end
        total++;
        if ({rr_out_valid, ll_out_valid, mp_out_valid} !== 12'h000) begin
            bad++; $display("FAIL reset_out_valid got=%h exp=000", {rr_out_valid, ll_out_valid, mp_out_valid});
        end
        total++;
        if (rr_pending !== 16'h0 || ll_pending !== 12'h0 || mp_pending !== 8'h0) begin
            bad++; $display("FAIL reset_pending got=%h/%h/%h exp=0", rr_pending, ll_pending, mp_pending);
        end
        total++;
        if ({rr_busy, ll_busy, mp_busy} !== 3'b000) begin
            bad++; $display("FAIL reset_busy got=%b exp=000", {rr_busy, ll_busy, mp_busy});
        end
        rr_in_valid = 2'b00;
        mp_in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Dispatch must be possible at the very first edge after release.
        mp_out_ready = 4'hF;
        mp_in_valid = 1'b1;
        mp_in_data = 16'h1234;
        #1;
        total++;
        if (mp_in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got=%b exp=1", mp_in_ready);
        end
        @(posedge clk);
        #1;
        mp_in_valid = 1'b0;
        total++;
        if (mp_out_valid !== 4'b0001 || mp_out_data[15:0] !== 16'h1234) begin
            bad++; $display("FAIL reset_release_dispatch got=%b/%h exp=0001/1234", mp_out_valid, mp_out_data[15:0]);
        end
    endtask

    task automatic test_rr_order();
        logic [15:0] exp_d;
        do_reset();
        rr_out_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rr_in_valid = 2'b01;
            exp_d = 16'h0100 + 16'(i);
            rr_in_data = {16'h0000, exp_d};
            #1;
            total++;
            if (rr_in_ready !== 2'b01) begin
                bad++; $display("FAIL rr_in_ready i=%0d got=%b exp=01", i, rr_in_ready);
            end
            @(posedge clk);
            #1;
            total++;
            if (rr_out_valid !== (4'b0001 << (i % 4))) begin
                bad++; $display("FAIL rr_target i=%0d got=%b exp=%b", i, rr_out_valid, 4'b0001 << (i % 4));
            end
            total++;
            if (rr_out_data[(i % 4)*16 +: 16] !== exp_d) begin
                bad++; $display("FAIL rr_data i=%0d got=%h exp=%h", i, rr_out_data[(i % 4)*16 +: 16], exp_d);
            end
        end
        rr_in_valid = 2'b00;
        @(posedge clk);
        #1;
        total++;
        if (rr_out_valid !== 4'b0000) begin
            bad++; $display("FAIL rr_drained got=%b exp=0000", rr_out_valid);
        end
        for (int j = 0; j < 4; j++) begin
            total++;
            if (rr_pending[j*4 +: 4] !== 4'd2) begin
                bad++; $display("FAIL rr_pending out=%0d got=%0d exp=2", j, rr_pending[j*4 +: 4]);
            end
        end
        total++;
        if (rr_busy !== 1'b1) begin
            bad++; $display("FAIL rr_busy_pending got=%b exp=1", rr_busy);
        end
    endtask

    task automatic test_fair_inputs();
        int          cnt0;
        int          cnt1;
        logic [15:0] exp_d;
        cnt0 = 0;
        cnt1 = 0;
        do_reset();
        rr_out_ready = 4'hF;
        rr_in_valid = 2'b11;
        rr_in_data = {16'hB000, 16'hA000};
        for (int i = 0; i < 16; i++) begin
            #1;
            total++;
            if (rr_in_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL fair_grant i=%0d got=%b exp=%b", i, rr_in_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (rr_in_ready == 2'b01) cnt0++;
            if (rr_in_ready == 2'b10) cnt1++;
            exp_d = (i % 2 == 0) ? 16'hA000 : 16'hB000;
            @(posedge clk);
            #1;
            total++;
            if (rr_out_valid !== (4'b0001 << (i % 4)) || rr_out_data[(i % 4)*16 +: 16] !== exp_d) begin
                bad++; $display("FAIL fair_land i=%0d got=%b/%h exp=%b/%h", i, rr_out_valid,
                                rr_out_data[(i % 4)*16 +: 16], 4'b0001 << (i % 4), exp_d);
            end
        end
        rr_in_valid = 2'b00;
        total++;
        if (cnt0 != 8 || cnt1 != 8) begin
            bad++; $display("FAIL fair_counts got=%0d/%0d exp=8/8", cnt0, cnt1);
        end
        @(posedge clk);
        #1;
        total++;
        if (rr_pending !== {4{4'd4}}) begin
            bad++; $display("FAIL fair_pending got=%h exp=4444", rr_pending);
        end
    endtask

    task automatic test_least_loaded();
        logic [3:0] masks [7];
        masks = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000};
        do_reset();
        ll_in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ll_out_ready = masks[k];
            ll_in_data = 16'h0010 + 16'(k);
            #1;
            total++;
            if (ll_out_valid !== masks[k] || ll_out_data[$clog2(masks[k])*16 +: 16] !== 16'h0010 + 16'(k)) begin
                bad++; $display("FAIL ll_setup k=%0d got=%b exp=%b", k, ll_out_valid, masks[k]);
            end
            @(posedge clk);
            #1;
        end
        ll_out_ready = 4'hF;
        ll_in_data = 16'h0055;
        #1;
        total++;
        if (ll_pending !== {3'd2, 3'd1, 3'd1, 3'd3}) begin
            bad++; $display("FAIL ll_pending_setup got=%h exp=%h", ll_pending, {3'd2, 3'd1, 3'd1, 3'd3});
        end
        total++;
        if (ll_in_ready !== 1'b1 || ll_out_valid !== 4'b0010 || ll_out_data[31:16] !== 16'h0055) begin
            bad++; $display("FAIL ll_first got=%b/%b/%h exp=1/0010/0055", ll_in_ready, ll_out_valid, ll_out_data[31:16]);
        end
        @(posedge clk);
        #1;
        ll_in_data = 16'h0066;
        #1;
        total++;
        if (ll_out_valid !== 4'b0100 || ll_out_data[47:32] !== 16'h0066) begin
            bad++; $display("FAIL ll_second got=%b/%h exp=0100/0066", ll_out_valid, ll_out_data[47:32]);
        end
        @(posedge clk);
        #1;
        ll_in_valid = 1'b0;
        total++;
        if (ll_pending !== {3'd2, 3'd2, 3'd2, 3'd3}) begin
            bad++; $display("FAIL ll_pending_final got=%h exp=%h", ll_pending, {3'd2, 3'd2, 3'd2, 3'd3});
        end
    endtask

    task automatic test_done_corner();
        do_reset();
        ll_out_ready = 4'b0001;
        ll_in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ll_pending[2:0] !== 3'd1) begin
            bad++; $display("FAIL done_setup got=%0d exp=1", ll_pending[2:0]);
        end
        ll_done = 4'b0001;
        #1;
        total++;
        if (ll_out_valid !== 4'b0001) begin
            bad++; $display("FAIL done_concurrent_dispatch got=%b exp=0001", ll_out_valid);
        end
        @(posedge clk);
        #1;
        ll_done = 4'b0000;
        ll_in_valid = 1'b0;
        total++;
        if (ll_pending[2:0] !== 3'd1) begin
            bad++; $display("FAIL done_concurrent got=%0d exp=1", ll_pending[2:0]);
        end
        ll_done = 4'b1000;
        @(posedge clk);
        #1;
        ll_done = 4'b0000;
        total++;
        if (ll_pending[11:9] !== 3'd0 || ll_pending[2:0] !== 3'd1) begin
            bad++; $display("FAIL done_zero got=%0d/%0d exp=0/1", ll_pending[11:9], ll_pending[2:0]);
        end
        ll_done = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        ll_done = 4'b0000;
        total++;
        if (ll_pending !== 12'h000) begin
            bad++; $display("FAIL done_underflow got=%h exp=000", ll_pending);
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        mp_out_ready = 4'hF;
        mp_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mp_in_data = 16'h0200 + 16'(i);
            @(posedge clk);
            #1;
        end
        #1;
        total++;
        if (mp_in_ready !== 1'b0 || mp_pending !== {4{2'd2}}) begin
            bad++; $display("FAIL full_block got=%b/%h exp=0/aa", mp_in_ready, mp_pending);
        end
        @(posedge clk);
        #1;
        mp_done = 4'b0100;
        #1;
        total++;
        if (mp_in_ready !== 1'b0 || mp_out_valid !== 4'b0000) begin
            bad++; $display("FAIL full_done_cycle got=%b/%b exp=0/0000", mp_in_ready, mp_out_valid);
        end
        @(posedge clk);
        #1;
        mp_done = 4'b0000;
        mp_in_data = 16'h0777;
        #1;
        total++;
        if (mp_in_ready !== 1'b1 || mp_pending[5:4] !== 2'd1) begin
            bad++; $display("FAIL full_reopen got=%b/%0d exp=1/1", mp_in_ready, mp_pending[5:4]);
        end
        @(posedge clk);
        #1;
        mp_in_valid = 1'b0;
        total++;
        if (mp_out_valid !== 4'b0100 || mp_out_data[47:32] !== 16'h0777 || mp_pending[5:4] !== 2'd2) begin
            bad++; $display("FAIL full_redispatch got=%b/%h/%0d exp=0100/0777/2", mp_out_valid, mp_out_data[47:32], mp_pending[5:4]);
        end
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        mp_out_ready = 4'b1110;
        mp_in_valid = 1'b1;
        mp_in_data = 16'hBEEF;
        @(posedge clk);
        #1;
        mp_in_valid = 1'b0;
        mp_in_data = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (mp_out_valid[0] !== 1'b1 || mp_out_data[15:0] !== 16'hBEEF) begin
                bad++; $display("FAIL hold_stable c=%0d got=%b/%h exp=1/beef", c, mp_out_valid[0], mp_out_data[15:0]);
            end
            @(posedge clk);
            #1;
        end
        do_reset();
        mp_out_ready = 4'b1110;
        mp_in_valid = 1'b1;
        mp_in_data = 16'hCAFE;
        @(posedge clk);
        #1;
        mp_in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mp_out_valid[0] !== 1'b1 || mp_out_data[15:0] !== 16'hCAFE) begin
            bad++; $display("FAIL hold_before_reset got=%b/%h exp=1/cafe", mp_out_valid[0], mp_out_data[15:0]);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (mp_out_valid !== 4'b0000 || mp_pending !== 8'h00 || mp_busy !== 1'b0) begin
            bad++; $display("FAIL async_clear got=%b/%h/%b exp=0000/00/0", mp_out_valid, mp_pending, mp_busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (mp_out_valid !== 4'b0000 || mp_pending !== 8'h00) begin
                bad++; $display("FAIL no_replay c=%0d got=%b/%h exp=0000/00", c, mp_out_valid, mp_pending);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_rr_order();
        test_fair_inputs();
        test_least_loaded();
        test_done_corner();
        test_full_backpressure();
        test_hold_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
